// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - Access size encodings carried on req_size.
//   - FSM state encoding used by load_store_unit.
//   - 32-bit word type used on the memory-side data paths.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic for the load/store unit.
//   Load side : ld_word, ld_offset, ld_size, ld_unsigned -> ld_result
//               (byte/half extracted from its lane, then sign- or zero-extended)
//   Store side: st_old, st_new, st_offset, st_size -> st_merged
//               (byte/half of st_new inserted into its lane of st_old)
// Half accesses select their lane with offset[1] only, and words ignore the
// offset, so a misaligned address is naturally treated as its aligned form.
import lsu_pkg::*;

module lsu_align (
    input  word_t      ld_word,
    input  logic [1:0] ld_offset,
    input  logic [1:0] ld_size,
    input  logic       ld_unsigned,
    output word_t      ld_result,
    input  word_t      st_old,
    input  word_t      st_new,
    input  logic [1:0] st_offset,
    input  logic [1:0] st_size,
    output word_t      st_merged
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = ld_word[{ld_offset, 3'b000} +: 8];
        ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            SZ_BYTE: ld_result = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_result = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_result = ld_word;
        endcase
    end

    always_comb begin
        st_merged = st_old;
        case (st_size)
            SZ_BYTE: st_merged[{st_offset, 3'b000} +: 8] = st_new[7:0];
            SZ_HALF: begin
                if (st_offset[1]) st_merged[31:16] = st_new[15:0];
                else              st_merged[15:0]  = st_new[15:0];
            end
            default: st_merged = st_new;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a word-addressed data memory port.
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   req_*               request from the core (valid/ready), byte address,
//                       size (00 byte, 01 half, 10 word, 11 illegal)
//   rsp_*               response to the core (valid/ready): load data + error
//   mem_*               word-aligned memory port; mem_read_data is combinational
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only in IDLE; rsp_valid is high only in RESP and
// rsp_data/rsp_err are stable while it waits for rsp_ready.
// Optional build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses return an error; otherwise they are performed at the aligned address.
import lsu_pkg::*;

module load_store_unit #(
    parameter int MEM_DEPTH  = 256,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  mem_write_en,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    lsu_state_e state;

    logic       we_q;
    logic [1:0] size_q;
    logic       uns_q;
    word_t      addr_q;
    word_t      wdata_q;
    word_t      merge_buf;

    logic  size_bad;
    logic  range_bad;
    logic  misalign;
    logic  req_err;
    word_t ld_result;
    word_t st_merged;

    always_comb begin
        size_bad  = (req_size == SZ_ILLEGAL);
        range_bad = (req_addr >= 32'(MEM_DEPTH * 4));
`ifdef LSU_MISALIGN_TRAP_EN
        misalign  = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        misalign  = 1'b0;
`endif
        req_err   = size_bad || range_bad || misalign;
    end

    lsu_align u_align (
        .ld_word     (mem_read_data),
        .ld_offset   (addr_q[1:0]),
        .ld_size     (size_q),
        .ld_unsigned (uns_q),
        .ld_result   (ld_result),
        .st_old      (merge_buf),
        .st_new      (wdata_q),
        .st_offset   (addr_q[1:0]),
        .st_size     (size_q),
        .st_merged   (st_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            merge_buf <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= req_size;
                        uns_q    <= req_unsigned;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rsp_data <= '0;
                        rsp_err  <= req_err;
                        // Errors skip the memory entirely.
                        state    <= req_err ? ST_RESP : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!we_q) begin
                        rsp_data <= ld_result;
                        state    <= ST_RESP;
                    end else if (size_q == SZ_WORD) begin
                        state <= ST_RESP;
                    end else begin
                        // Sub-word store: capture the old word, merge next cycle.
                        merge_buf <= mem_read_data;
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: state <= ST_RESP;
                ST_RESP: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign mem_addr  = {addr_q[31:2], 2'b00};

    // Decoded only from registers, so reset removes a write in flight at once.
    assign mem_write_en = (state == ST_WRITE) ||
                          ((state == ST_ACCESS) && we_q && (size_q == SZ_WORD));

    always_comb begin
        mem_write_data = '0;
        case (state)
            ST_ACCESS: if (we_q && (size_q == SZ_WORD)) mem_write_data = wdata_q;
            ST_WRITE:  mem_write_data = st_merged;
            default:   mem_write_data = '0;
        endcase
    end

endmodule
